uart_bus_sequencer: RTL and testbench

- Bus master that owns the 4-bit address / 8-bit data register interface of the UART core.
- After reset it writes three configuration registers: CTRL1, CTRL2, CTRL3.
- It then polls the status register continuously. It drains the RX FIFO to a byte stream and fills the TX FIFO from two byte-stream requesters.
- The TX requesters are arbitrated round-robin. This gives the rest of the FPGA a plain valid/ready view of the UART with no software.

---
 rtl/uart_seq_pkg.sv | 35 +++
 rtl/uart_bus_access.sv | 78 +++++++
 rtl/uart_bus_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_uart_bus_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_seq_pkg.sv
// Shared types and default constants for the UART bus sequencer.
//   seq_state_t  : sequencer FSM states
//   bus_phase_t  : phases of one 3-cycle register access
//   DEF_*        : default register map and status bit positions
package uart_seq_pkg;

  typedef enum logic [2:0] {
    ST_CFG1,
    ST_CFG2,
    ST_CFG3,
    ST_POLL,
    ST_DECIDE,
    ST_WR_TX,
    ST_RD_RX,
    ST_RX_HOLD
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } bus_phase_t;

  localparam logic [3:0] DEF_ADDR_CTRL1  = 4'h0;
  localparam logic [3:0] DEF_ADDR_CTRL2  = 4'h1;
  localparam logic [3:0] DEF_ADDR_CTRL3  = 4'h2;
  localparam logic [3:0] DEF_ADDR_STATUS = 4'h3;
  localparam logic [3:0] DEF_ADDR_TXDATA = 4'h4;
  localparam logic [3:0] DEF_ADDR_RXDATA = 4'h5;

  localparam int unsigned DEF_STS_TXFULL_BIT  = 1;
  localparam int unsigned DEF_STS_RXEMPTY_BIT = 0;

endpackage

// File: rtl/uart_bus_access.sv
// Three-cycle register access engine (SETUP / STROBE / HOLD, then IDLE).
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_start             : begin an access (sampled only while idle)
//   i_rd                : 1 = read, 0 = write
//   i_addr, i_wdata     : access address / write data
//   i_data              : read data from the UART core
//   o_addr, o_wdata     : address / write data pins (held between accesses)
//   o_cs_n, o_rd_n, o_we_n : active-low bus controls
//   o_idle              : engine can accept i_start this cycle
//   o_done              : high during HOLD, the last cycle of an access
//   o_rdata             : read data, captured at the end of STROBE
module uart_bus_access
  import uart_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rd,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_data,
  output logic [3:0] o_addr,
  output logic [7:0] o_wdata,
  output logic       o_cs_n,
  output logic       o_rd_n,
  output logic       o_we_n,
  output logic       o_idle,
  output logic       o_done,
  output logic [7:0] o_rdata
);

  bus_phase_t r_phase;
  logic       r_rd;
  logic [3:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= PH_IDLE;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_phase)
        PH_IDLE: begin
          if (i_start) begin
            r_phase <= PH_SETUP;
            r_rd    <= i_rd;
            r_addr  <= i_addr;
            if (!i_rd) r_wdata <= i_wdata;
          end
        end
        PH_SETUP:  r_phase <= PH_STROBE;
        PH_STROBE: begin
          r_phase <= PH_HOLD;
          if (r_rd) r_rdata <= i_data;
        end
        PH_HOLD:   r_phase <= PH_IDLE;
        default:   r_phase <= PH_IDLE;
      endcase
    end
  end

  // Controls decode straight from the async-reset phase register so a reset
  // mid-access releases the bus immediately.
  assign o_cs_n  = (r_phase == PH_IDLE);
  assign o_rd_n  = !((r_phase == PH_STROBE) && r_rd);
  assign o_we_n  = !((r_phase == PH_STROBE) && !r_rd);
  assign o_idle  = (r_phase == PH_IDLE);
  assign o_done  = (r_phase == PH_HOLD);
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_bus_sequencer.sv
// Bus master for the UART core register interface: writes CTRL1..3 after
// reset, then polls status, drains the RX FIFO to a valid/ready stream and
// fills the TX FIFO from two round-robin arbitrated requesters.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   AddrBus_o, DataBus_o          : register address / write data
//   n_ChipSelect_o, n_rd_o, n_we_o: active-low bus controls
//   DataBus_i                     : register read data
//   TxDataA_i/p_TxValidA_i/p_TxReadyA_o : requester A (ready = 1-cycle pulse)
//   TxDataB_i/p_TxValidB_i/p_TxReadyB_o : requester B
//   RxData_o/p_RxValid_o/p_RxReady_i    : received byte stream
//   p_CfgDone_o                   : configuration written
module uart_bus_sequencer
  import uart_seq_pkg::*;
#(
  parameter logic [7:0]  CFG_CTRL1       = 8'h40,
  parameter logic [7:0]  CFG_CTRL2       = 8'h1A,
  parameter logic [7:0]  CFG_CTRL3       = 8'h00,
  parameter logic [3:0]  ADDR_CTRL1      = DEF_ADDR_CTRL1,
  parameter logic [3:0]  ADDR_CTRL2      = DEF_ADDR_CTRL2,
  parameter logic [3:0]  ADDR_CTRL3      = DEF_ADDR_CTRL3,
  parameter logic [3:0]  ADDR_STATUS     = DEF_ADDR_STATUS,
  parameter logic [3:0]  ADDR_TXDATA     = DEF_ADDR_TXDATA,
  parameter logic [3:0]  ADDR_RXDATA     = DEF_ADDR_RXDATA,
  parameter int unsigned STS_TXFULL_BIT  = DEF_STS_TXFULL_BIT,
  parameter int unsigned STS_RXEMPTY_BIT = DEF_STS_RXEMPTY_BIT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] AddrBus_o,
  output logic       n_ChipSelect_o,
  output logic       n_rd_o,
  output logic       n_we_o,
  output logic [7:0] DataBus_o,
  input  logic [7:0] DataBus_i,
  input  logic [7:0] TxDataA_i,
  input  logic       p_TxValidA_i,
  output logic       p_TxReadyA_o,
  input  logic [7:0] TxDataB_i,
  input  logic       p_TxValidB_i,
  output logic       p_TxReadyB_o,
  output logic [7:0] RxData_o,
  output logic       p_RxValid_o,
  input  logic       p_RxReady_i,
  output logic       p_CfgDone_o
);

  seq_state_t r_state;
  seq_state_t w_next;

  logic       w_start;
  logic       w_rd;
  logic [3:0] w_addr;
  logic [7:0] w_wdata;
  logic       w_idle;
  logic       w_done;
  logic [7:0] w_rdata;

  logic       r_rr_b;      // round-robin pointer: 0 = A has priority, 1 = B
  logic       r_cfg_done;
  logic [7:0] r_tx_byte;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  logic       w_rx_go;
  logic       w_tx_go;
  logic       w_grant_a;
  logic       w_grant_b;

  uart_bus_access u_access (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (w_start),
    .i_rd    (w_rd),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .i_data  (DataBus_i),
    .o_addr  (AddrBus_o),
    .o_wdata (DataBus_o),
    .o_cs_n  (n_ChipSelect_o),
    .o_rd_n  (n_rd_o),
    .o_we_n  (n_we_o),
    .o_idle  (w_idle),
    .o_done  (w_done),
    .o_rdata (w_rdata)
  );

  // In DECIDE the engine's read register still holds the status byte from
  // the POLL access that just finished.
  assign w_rx_go   = !w_rdata[STS_RXEMPTY_BIT] && !r_rx_valid;
  assign w_tx_go   = !w_rdata[STS_TXFULL_BIT] && (p_TxValidA_i || p_TxValidB_i);
  assign w_grant_a = w_tx_go && p_TxValidA_i && (!p_TxValidB_i || !r_rr_b);
  assign w_grant_b = w_tx_go && p_TxValidB_i && (!p_TxValidA_i || r_rr_b);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_CFG1;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CFG1:    if (w_done) w_next = ST_CFG2;
      ST_CFG2:    if (w_done) w_next = ST_CFG3;
      ST_CFG3:    if (w_done) w_next = ST_POLL;
      ST_POLL:    if (w_done) w_next = ST_DECIDE;
      ST_DECIDE: begin
        if (w_rx_go)                     w_next = ST_RD_RX;
        else if (w_grant_a || w_grant_b) w_next = ST_WR_TX;
        else                             w_next = ST_POLL;
      end
      ST_WR_TX:   if (w_done) w_next = ST_POLL;
      ST_RD_RX:   if (w_done) w_next = ST_RX_HOLD;
      ST_RX_HOLD: w_next = ST_POLL;
      default:    w_next = ST_CFG1;
    endcase
  end

  // Output logic: one access is launched per access state, as soon as the
  // engine is idle; the state always changes on the access's done cycle.
  always_comb begin
    w_start      = 1'b0;
    w_rd         = 1'b0;
    w_addr       = ADDR_STATUS;
    w_wdata      = '0;
    p_TxReadyA_o = 1'b0;
    p_TxReadyB_o = 1'b0;
    case (r_state)
      ST_CFG1: begin
        w_start = w_idle;
        w_addr  = ADDR_CTRL1;
        w_wdata = CFG_CTRL1;
      end
      ST_CFG2: begin
        w_start = w_idle;
        w_addr  = ADDR_CTRL2;
        w_wdata = CFG_CTRL2;
      end
      ST_CFG3: begin
        w_start = w_idle;
        w_addr  = ADDR_CTRL3;
        w_wdata = CFG_CTRL3;
      end
      ST_POLL: begin
        w_start = w_idle;
        w_rd    = 1'b1;
        w_addr  = ADDR_STATUS;
      end
      ST_DECIDE: begin
        if (!w_rx_go) begin
          p_TxReadyA_o = w_grant_a;
          p_TxReadyB_o = w_grant_b;
        end
      end
      ST_WR_TX: begin
        w_start = w_idle;
        w_addr  = ADDR_TXDATA;
        w_wdata = r_tx_byte;
      end
      ST_RD_RX: begin
        w_start = w_idle;
        w_rd    = 1'b1;
        w_addr  = ADDR_RXDATA;
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  // Arbiter, configuration flag and RX output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_b     <= 1'b0;
      r_cfg_done <= 1'b0;
      r_tx_byte  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (r_state == ST_CFG3 && w_done) r_cfg_done <= 1'b1;

      if (r_state == ST_DECIDE && !w_rx_go) begin
        if (w_grant_a) begin
          r_tx_byte <= TxDataA_i;
          r_rr_b    <= 1'b1;
        end else if (w_grant_b) begin
          r_tx_byte <= TxDataB_i;
          r_rr_b    <= 1'b0;
        end
      end

      if (r_state == ST_RX_HOLD) begin
        r_rx_data  <= w_rdata;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && p_RxReady_i) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign RxData_o    = r_rx_data;
  assign p_RxValid_o = r_rx_valid;
  assign p_CfgDone_o = r_cfg_done;

endmodule

// File: tb/tb_uart_bus_sequencer.sv
module tb_uart_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] AddrBus_o;
  logic       n_ChipSelect_o, n_rd_o, n_we_o;
  logic [7:0] DataBus_o, DataBus_i;
  logic [7:0] TxDataA_i, TxDataB_i;
  logic       p_TxValidA_i, p_TxValidB_i;
  logic       p_TxReadyA_o, p_TxReadyB_o;
  logic [7:0] RxData_o;
  logic       p_RxValid_o, p_RxReady_i, p_CfgDone_o;

  always #5 clk = ~clk;

  uart_bus_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .AddrBus_o      (AddrBus_o),
    .n_ChipSelect_o (n_ChipSelect_o),
    .n_rd_o         (n_rd_o),
    .n_we_o         (n_we_o),
    .DataBus_o      (DataBus_o),
    .DataBus_i      (DataBus_i),
    .TxDataA_i      (TxDataA_i),
    .p_TxValidA_i   (p_TxValidA_i),
    .p_TxReadyA_o   (p_TxReadyA_o),
    .TxDataB_i      (TxDataB_i),
    .p_TxValidB_i   (p_TxValidB_i),
    .p_TxReadyB_o   (p_TxReadyB_o),
    .RxData_o       (RxData_o),
    .p_RxValid_o    (p_RxValid_o),
    .p_RxReady_i    (p_RxReady_i),
    .p_CfgDone_o    (p_CfgDone_o)
  );

  // UART core register model: status and RX data registers
  logic [7:0] sts;
  logic [7:0] rxb;
  assign DataBus_i = (AddrBus_o == 4'h3) ? sts :
                     (AddrBus_o == 4'h5) ? rxb : 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];   // expected writes {addr, data}
  logic [3:0]  ord_q[$];   // order of TX writes (4) and RX reads (5)
  logic [11:0] e_w;
  int sts_rd = 0, rx_rd = 0, wr_cnt = 0, gA = 0, gB = 0, cs_run = 0;
  logic prevA = 1'b0, prevB = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus monitor / scoreboard consumer
  always @(negedge clk) begin
    if (rst) begin
      cs_run = 0;
      prevA  = 1'b0;
      prevB  = 1'b0;
    end else begin
      if (!n_ChipSelect_o) cs_run++;
      else if (cs_run != 0) begin
        chk("access_len", 16'(cs_run), 16'd3);
        cs_run = 0;
      end
      if (!n_we_o || !n_rd_o) chk("strobe_cs", 16'(n_ChipSelect_o), 16'd0);
      if (!n_we_o) begin
        wr_cnt++;
        if (AddrBus_o == 4'h4) ord_q.push_back(4'h4);
        chk("wr_expected", 16'(exp_q.size() > 0), 16'd1);
        if (exp_q.size() > 0) begin
          e_w = exp_q.pop_front();
          chk("wr_addr_data", {4'h0, AddrBus_o, DataBus_o}, {4'h0, e_w});
        end
      end
      if (!n_rd_o) begin
        if (AddrBus_o == 4'h3) sts_rd++;
        if (AddrBus_o == 4'h5) begin
          rx_rd++;
          ord_q.push_back(4'h5);
        end
      end
      if (p_TxReadyA_o) begin
        gA++;
        chk("readyA_pulse", 16'(prevA), 16'd0);
      end
      if (p_TxReadyB_o) begin
        gB++;
        chk("readyB_pulse", 16'(prevB), 16'd0);
      end
      prevA = p_TxReadyA_o;
      prevB = p_TxReadyB_o;
    end
  end

  int t, pc, a0, w0, s0, r0, b0;

  initial begin
    sts = 8'h01; rxb = 8'h00;
    TxDataA_i = 8'h00; TxDataB_i = 8'h00;
    p_TxValidA_i = 1'b0; p_TxValidB_i = 1'b0; p_RxReady_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_addr",  16'(AddrBus_o), 16'h0);
    chk("rst_cs",    16'(n_ChipSelect_o), 16'h1);
    chk("rst_rd",    16'(n_rd_o), 16'h1);
    chk("rst_we",    16'(n_we_o), 16'h1);
    chk("rst_data",  16'(DataBus_o), 16'h0);
    chk("rst_ready", 16'({p_TxReadyA_o, p_TxReadyB_o}), 16'h0);
    chk("rst_rxv",   16'(p_RxValid_o), 16'h0);
    chk("rst_rxd",   16'(RxData_o), 16'h0);
    chk("rst_cfg",   16'(p_CfgDone_o), 16'h0);

    // Configuration sequence
    exp_q.push_back(12'h040); exp_q.push_back(12'h11A); exp_q.push_back(12'h200);
    rst = 1'b0;
    t = 0;
    while (!p_CfgDone_o && t < 100) begin @(negedge clk); t++; end
    chk("cfg_done", 16'(p_CfgDone_o), 16'h1);
    chk("cfg_left", 16'(exp_q.size()), 16'd0);
    chk("cfg_wrcnt", 16'(wr_cnt), 16'd3);
    chk("cfg_no_poll_yet", 16'(sts_rd), 16'd0);
    repeat (12) @(negedge clk);
    chk("poll_started", 16'(sts_rd >= 2), 16'd1);

    // Round-robin: both valid, 4 grants
    exp_q.push_back(12'h455); exp_q.push_back(12'h4AA);
    exp_q.push_back(12'h455); exp_q.push_back(12'h4AA);
    TxDataA_i = 8'h55; TxDataB_i = 8'hAA;
    p_TxValidA_i = 1'b1; p_TxValidB_i = 1'b1;
    t = 0; pc = 0;
    while (pc < 4 && t < 200) begin
      @(negedge clk); t++;
      if (p_TxReadyA_o || p_TxReadyB_o) pc++;
    end
    chk("rr_grants", 16'(pc), 16'd4);
    @(posedge clk); #1;
    p_TxValidA_i = 1'b0; p_TxValidB_i = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    chk("rr_drained", 16'(exp_q.size()), 16'd0);
    chk("rr_gA", 16'(gA), 16'd2);
    chk("rr_gB", 16'(gB), 16'd2);

    // TX full: only status reads
    sts = 8'h03;
    repeat (10) @(negedge clk);
    TxDataA_i = 8'h3C; p_TxValidA_i = 1'b1;
    a0 = gA; w0 = wr_cnt; s0 = sts_rd; r0 = rx_rd;
    repeat (40) @(negedge clk);
    chk("full_no_grant", 16'(gA - a0), 16'd0);
    chk("full_no_write", 16'(wr_cnt - w0), 16'd0);
    chk("full_no_rx", 16'(rx_rd - r0), 16'd0);
    chk("full_polling", 16'(sts_rd - s0 >= 6), 16'd1);
    exp_q.push_back(12'h43C);
    sts = 8'h01;
    t = 0;
    while (gA == a0 && t < 40) begin @(negedge clk); t++; end
    chk("unfull_grant", 16'(gA - a0), 16'd1);
    @(posedge clk); #1;
    p_TxValidA_i = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin @(negedge clk); t++; end
    chk("unfull_drained", 16'(exp_q.size()), 16'd0);
    repeat (10) @(negedge clk);
    chk("unfull_one_wr", 16'(wr_cnt - w0), 16'd1);

    // RX backpressure
    sts = 8'h00; rxb = 8'hC3;
    r0 = rx_rd;
    t = 0;
    while (!p_RxValid_o && t < 40) begin @(negedge clk); t++; end
    chk("rx_valid", 16'(p_RxValid_o), 16'h1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rx_hold_data", 16'(RxData_o), 16'h00C3);
      chk("rx_hold_valid", 16'(p_RxValid_o), 16'h1);
    end
    chk("rx_one_read", 16'(rx_rd - r0), 16'd1);
    rxb = 8'h96;
    p_RxReady_i = 1'b1;
    @(negedge clk);
    chk("rx_valid_drop", 16'(p_RxValid_o), 16'h0);
    p_RxReady_i = 1'b0;
    t = 0;
    while (rx_rd == r0 + 1 && t < 40) begin @(negedge clk); t++; end
    chk("rx_reread", 16'(rx_rd - r0), 16'd2);
    sts = 8'h01;
    t = 0;
    while (!p_RxValid_o && t < 40) begin @(negedge clk); t++; end
    chk("rx2_valid", 16'(p_RxValid_o), 16'h1);
    chk("rx2_data", 16'(RxData_o), 16'h0096);
    p_RxReady_i = 1'b1;
    @(negedge clk);
    chk("rx2_drop", 16'(p_RxValid_o), 16'h0);
    p_RxReady_i = 1'b0;

    // RX has priority over TX
    repeat (10) @(negedge clk);
    sts = 8'h00; rxb = 8'h71;
    s0 = sts_rd;
    t = 0;
    while (sts_rd == s0 && t < 20) begin @(negedge clk); t++; end
    TxDataA_i = 8'h11; p_TxValidA_i = 1'b1;
    exp_q.push_back(12'h411);
    b0 = ord_q.size(); a0 = gA;
    t = 0;
    while (gA == a0 && t < 60) begin @(negedge clk); t++; end
    chk("prio_grant", 16'(gA - a0), 16'd1);
    @(posedge clk); #1;
    p_TxValidA_i = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin @(negedge clk); t++; end
    chk("prio_drained", 16'(exp_q.size()), 16'd0);
    chk("prio_count", 16'(ord_q.size() - b0), 16'd2);
    if (ord_q.size() >= b0 + 2) begin
      chk("prio_first_rx", 16'(ord_q[b0]), 16'd5);
      chk("prio_then_tx", 16'(ord_q[b0 + 1]), 16'd4);
    end
    sts = 8'h01;
    chk("prio_rxdata", 16'(RxData_o), 16'h0071);
    chk("prio_rxvalid", 16'(p_RxValid_o), 16'h1);
    p_RxReady_i = 1'b1;
    @(negedge clk);
    p_RxReady_i = 1'b0;

    // Reset during TX write strobe
    repeat (10) @(negedge clk);
    TxDataA_i = 8'hE7; p_TxValidA_i = 1'b1;
    exp_q.push_back(12'h4E7);
    t = 0;
    while (!(!n_we_o && AddrBus_o == 4'h4) && t < 60) begin @(negedge clk); t++; end
    chk("mid_strobe_found", 16'(!n_we_o && AddrBus_o == 4'h4), 16'h1);
    p_TxValidA_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", 16'(n_we_o), 16'h1);
    chk("mid_rst_cs", 16'(n_ChipSelect_o), 16'h1);
    chk("mid_rst_rd", 16'(n_rd_o), 16'h1);
    chk("mid_rst_cfg", 16'(p_CfgDone_o), 16'h0);
    repeat (2) @(negedge clk);
    chk("mid_tx_seen", 16'(exp_q.size()), 16'd0);
    exp_q.push_back(12'h040); exp_q.push_back(12'h11A); exp_q.push_back(12'h200);
    w0 = wr_cnt;
    rst = 1'b0;
    t = 0;
    while (!p_CfgDone_o && t < 100) begin @(negedge clk); t++; end
    chk("recfg_done", 16'(p_CfgDone_o), 16'h1);
    chk("recfg_left", 16'(exp_q.size()), 16'd0);
    chk("recfg_wrcnt", 16'(wr_cnt - w0), 16'd3);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
